// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : UART transmit stage fed by a byte FIFO with registered read
//               data. Pops one byte whenever the FIFO is non-empty and sends
//               it as start + 8 data bits (LSB first) + optional parity +
//               1 or 2 stop bits, draining the FIFO back-to-back.
// Ports       : clk        - clock, all logic on the rising edge
//               rst        - synchronous active-high reset
//               fifo_empty - FIFO empty flag
//               fifo_data  - FIFO read data, valid the cycle after fifo_rd
//               fifo_rd    - one-cycle FIFO read strobe per byte
//               tx         - registered serial line, idles high
//               busy       - high whenever a frame is being handled
//               tx_done    - one-cycle pulse in the first idle cycle after
//                            a frame's last stop cycle
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          c_STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit                  c_HAS_PAR   = (PARITY_EN != 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_LOAD   = 3'd2;
    localparam logic [2:0] c_START  = 3'd3;
    localparam logic [2:0] c_DATA   = 3'd4;
    localparam logic [2:0] c_PARITY = 3'd5;
    localparam logic [2:0] c_STOP   = 3'd6;

    logic [2:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_idx;      // data bit index in DATA, stop bit index in STOP
    logic [7:0]          r_shreg;
    logic                r_tx;
    logic                r_done;

    logic [2:0]          w_state_next;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [c_BAUD_W-1:0] w_baud_inc;
    logic [2:0]          w_idx_next;
    logic                w_done_next;
    logic                w_tx_next;
    logic                w_bit_end;
    logic                w_par;

    if (PARITY_EN == 2) begin : g_par_odd
        assign w_par = ~^r_shreg;
    end else begin : g_par_even
        assign w_par = ^r_shreg;
    end

    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    assign w_baud_inc = w_bit_end ? '0 : r_baud + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = '0;
        w_idx_next   = r_idx;
        w_done_next  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!fifo_empty) w_state_next = c_FETCH;
            end
            c_FETCH: begin
                w_state_next = c_LOAD;
            end
            c_LOAD: begin
                w_state_next = c_START;
                w_idx_next   = 3'd0;
            end
            c_START: begin
                w_baud_next = w_baud_inc;
                if (w_bit_end) w_state_next = c_DATA;
            end
            c_DATA: begin
                w_baud_next = w_baud_inc;
                if (w_bit_end) begin
                    if (r_idx == 3'd7) begin
                        w_idx_next   = 3'd0;
                        w_state_next = c_HAS_PAR ? c_PARITY : c_STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            c_PARITY: begin
                w_baud_next = w_baud_inc;
                if (w_bit_end) w_state_next = c_STOP;
            end
            c_STOP: begin
                w_baud_next = w_baud_inc;
                if (w_bit_end) begin
                    if (r_idx == c_STOP_LAST) begin
                        w_idx_next   = 3'd0;
                        w_state_next = c_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_idx_next   = 3'd0;
            end
        endcase
    end

    // The line level is decoded from the state being entered so the
    // registered tx changes on the same edge as the state, giving every
    // serial bit exactly CLKS_PER_BIT cycles.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            c_START:  w_tx_next = 1'b0;
            c_DATA:   w_tx_next = r_shreg[w_idx_next];
            c_PARITY: w_tx_next = w_par;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
        end
    end

    // Data register needs no reset: it is always loaded before it is sent.
    always_ff @(posedge clk) begin
        if (r_state == c_LOAD) r_shreg <= fifo_data;
    end

    assign fifo_rd = (r_state == c_FETCH);
    assign busy    = (r_state != c_IDLE);
    assign tx      = r_tx;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Bench for fifo_uart_tx. Four instances (N=4) share stimulus:
//               lane 0 no parity/1 stop, lane 1 even parity, lane 2 odd
//               parity, lane 3 no parity/2 stop bits. Each lane has its own
//               registered-read FIFO model and an expected-waveform queue
//               built from the frame format.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_N = 4;
    localparam int c_LANES = 4;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic rd;
        logic idle;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_en = 1'b0;
    logic [7:0] push_byte = 8'h00;

    logic [c_LANES-1:0] fe = '1;
    logic [7:0]         fdata [c_LANES];
    logic [c_LANES-1:0] rd_w, tx_w, busy_w, done_w;

    logic [7:0] fq [c_LANES][$];
    ent_t       eq [c_LANES][$];

    int  errors = 0;
    int  checks = 0;
    int  tmo_cnt = 0;
    bit  tb_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_LANES; g++) begin : g_dut
        fifo_uart_tx #(
            .CLKS_PER_BIT(c_N),
            .PARITY_EN   ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .STOP_BITS   ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .fifo_empty(fe[g]),
            .fifo_data (fdata[g]),
            .fifo_rd   (rd_w[g]),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .tx_done   (done_w[g])
        );
    end

    // FIFO models: registered read data, flag updated at the clock edge.
    initial for (int l = 0; l < c_LANES; l++) fdata[l] = 8'h00;
    always @(posedge clk) begin
        for (int l = 0; l < c_LANES; l++) begin
            if (rd_w[l] === 1'b1 && fq[l].size() > 0) fdata[l] <= fq[l].pop_front();
            if (push_en) fq[l].push_back(push_byte);
            fe[l] <= (fq[l].size() == 0);
        end
    end

    function automatic int par_of(input int l);
        return (l == 1) ? 1 : ((l == 2) ? 2 : 0);
    endfunction

    function automatic int stop_of(input int l);
        return (l == 3) ? 2 : 1;
    endfunction

    function automatic ent_t mk(input logic t, input logic b, input logic d, input logic r, input logic i);
        ent_t e;
        e.tx = t; e.busy = b; e.done = d; e.rd = r; e.idle = i;
        return e;
    endfunction

    task automatic put(input int l, input ent_t e, input int cnt);
        for (int k = 0; k < cnt; k++) eq[l].push_back(e);
    endtask

    // Expected per-cycle outputs from the FETCH cycle to the tx_done cycle.
    task automatic build_frame(input int l, input logic [7:0] b);
        logic pbit;
        put(l, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 1);             // fetch
        put(l, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1);             // load
        put(l, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0), c_N);           // start
        for (int i = 0; i < 8; i++) put(l, mk(b[i], 1'b1, 1'b0, 1'b0, 1'b0), c_N);
        if (par_of(l) != 0) begin
            pbit = ($countones(b) % 2 == 1) ? (par_of(l) == 1) : (par_of(l) == 2);
            put(l, mk(pbit, 1'b1, 1'b0, 1'b0, 1'b0), c_N);
        end
        put(l, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), c_N * stop_of(l));
        put(l, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1), 1);             // first idle, tx_done
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Checker: model update and per-cycle comparison on the falling edge.
    initial begin : p_check
        bit         armed;
        int         cyc;
        ent_t       e;
        logic [9:0] got10;
        logic       rx_prev;
        int         rx_cnt;
        logic [7:0] rx_byte;
        logic [7:0] rx_log [$];
        logic [7:0] exp_rx [12];
        int         rd_cnt [c_LANES];
        int         done_cnt [c_LANES];

        armed = 1'b0; cyc = 0; rx_prev = 1'b1; rx_cnt = -1; rx_byte = 8'h00;
        exp_rx = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                   8'h07, 8'h5A, 8'hFF};
        for (int l = 0; l < c_LANES; l++) begin rd_cnt[l] = 0; done_cnt[l] = 0; end

        // Hand-computed pins on the model itself.
        build_frame(0, 8'hA5);
        chk("pin A5 entries", eq[0].size(), 43);
        got10 = '0;
        for (int k = 0; k < 10; k++) got10 = {got10[8:0], eq[0][3 + 4 * k].tx};
        chk("pin A5 line levels", got10, 10'b0101001011);
        chk("pin A5 fetch/load rd", {eq[0][0].rd, eq[0][1].rd}, 2'b10);
        chk("pin A5 done slot", {eq[0][42].tx, eq[0][42].busy, eq[0][42].done}, 3'b101);
        eq[0].delete();
        build_frame(1, 8'h07);
        chk("pin even entries", eq[1].size(), 47);
        chk("pin even parity", eq[1][39].tx, 1);
        eq[1].delete();
        build_frame(2, 8'h07);
        chk("pin odd parity", eq[2][39].tx, 0);
        eq[2].delete();
        build_frame(3, 8'hFF);
        chk("pin 2stop entries", eq[3].size(), 47);
        got10 = '0;
        for (int k = 38; k < 46; k++) got10 = {got10[8:0], eq[3][k].tx & ~eq[3][k].done};
        chk("pin 2stop high run", got10, 10'h0FF);
        chk("pin 2stop done at +44", eq[3][46].done, 1);
        eq[3].delete();

        forever begin
            @(negedge clk);
            cyc++;
            if (tb_done) begin
                chk("wait timeouts", tmo_cnt, 0);
                chk("lane0 frames decoded", rx_log.size(), 12);
                for (int i = 0; i < 12 && i < rx_log.size(); i++)
                    chk($sformatf("lane0 decoded byte %0d", i), rx_log[i], exp_rx[i]);
                for (int l = 0; l < c_LANES; l++) begin
                    chk($sformatf("lane%0d fifo_rd pulses", l), rd_cnt[l], 13);
                    chk($sformatf("lane%0d tx_done pulses", l), done_cnt[l], 12);
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            for (int l = 0; l < c_LANES; l++) begin
                e = (eq[l].size() > 0) ? eq[l].pop_front() : mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                if (armed) begin
                    chk($sformatf("lane%0d cyc%0d {tx,busy,tx_done,fifo_rd}", l, cyc),
                        {tx_w[l], busy_w[l], done_w[l], rd_w[l]},
                        {e.tx, e.busy, e.done, e.rd});
                    if (rd_w[l] === 1'b1) rd_cnt[l]++;
                    if (done_w[l] === 1'b1) done_cnt[l]++;
                end
                if (rst) eq[l].delete();
                else if (e.idle && !fe[l]) build_frame(l, fq[l][0]);
            end
            // Independent receiver on lane 0, sampling mid-bit.
            if (armed) begin
                if (rst) rx_cnt = -1;
                else if (rx_cnt < 0) begin
                    if (tx_w[0] == 1'b0 && rx_prev == 1'b1) rx_cnt = 0;
                end else begin
                    rx_cnt++;
                    if (rx_cnt >= 6 && rx_cnt % 4 == 2) rx_byte[(rx_cnt - 6) / 4] = tx_w[0];
                    if (rx_cnt == 34) begin
                        rx_log.push_back(rx_byte);
                        rx_cnt = -1;
                    end
                end
                rx_prev = tx_w[0];
            end
            if (rst) armed = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [7:0] b);
        push_en = 1'b1;
        push_byte = b;
        step();
        push_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            step();
            ok = (fe == '1) && (busy_w == '0);
        end
        if (!ok) tmo_cnt++;
        repeat (3) step();
    endtask

    initial begin : p_stim
        #1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (100) step();                       // idle with empty FIFO

        push_b(8'hA5);                             // single byte
        wait_idle();

        rst = 1'b1;                                // fill FIFO, then release
        for (int i = 0; i < 8; i++) push_b(8'(i));
        rst = 1'b0;
        wait_idle();

        push_b(8'h07);                             // parity lanes
        wait_idle();

        push_b(8'h3C);                             // reset during data bit 3
        push_b(8'h5A);
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle();

        push_b(8'hFF);                             // two stop bits on lane 3
        wait_idle();

        tb_done = 1'b1;
        repeat (5) step();
    end

endmodule
`default_nettype wire
